// File: rtl/decode_unit.sv
// RV32I single-cycle instruction decoder: combinational field/immediate/control decode
// plus a run flag that holds state-changing strobes low until the core leaves reset.
module decode_unit #(
    parameter int ADDRESS_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    branch,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wEn,
    output logic                    branch_op,
    output logic [31:0]             imm32,
    output logic [1:0]              op_A_sel,
    output logic                    op_B_sel,
    output logic [5:0]              ALU_Control,
    output logic                    mem_wEn,
    output logic                    wb_sel
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    logic                    run_q;
    logic                    run_d;
    logic [6:0]              opcode_s;
    logic [2:0]              funct3_s;
    logic [6:0]              funct7_s;
    logic [31:0]             imm_i_s;
    logic [31:0]             imm_st_s;
    logic [31:0]             imm_b_s;
    logic [31:0]             imm_u_s;
    logic [31:0]             imm_j_s;
    logic [31:0]             imm_s;
    logic [5:0]              alu_s;
    logic [1:0]              opa_s;
    logic                    opb_s;
    logic                    wen_s;
    logic                    mwen_s;
    logic                    wbs_s;
    logic                    bop_s;
    logic                    jump_s;
    logic                    lui_s;
    logic [ADDRESS_BITS-1:0] tgt_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];

    assign imm_i_s  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_st_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b_s  = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u_s  = {instruction[31:12], 12'b0};
    assign imm_j_s  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};

    // Run flag: cleared while reset is low, set on the first edge after release.
    assign run_d = 1'b1;

    // Run flag register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    // Opcode decode into immediate, ALU op, operand selects, controls and redirect target.
    always_comb begin
        imm_s  = 32'd0;
        alu_s  = 6'b000000;
        opa_s  = 2'b00;
        opb_s  = 1'b1;
        wen_s  = 1'b0;
        mwen_s = 1'b0;
        wbs_s  = 1'b0;
        bop_s  = 1'b0;
        jump_s = 1'b0;
        lui_s  = 1'b0;
        tgt_s  = {ADDRESS_BITS{1'b0}};
        case (opcode_s)
            OP_R: begin
                wen_s = 1'b1;
                opb_s = 1'b0;
                if (funct7_s == FUNCT7_ALT && funct3_s == 3'b000) begin
                    alu_s = 6'b001000;
                end else if (funct7_s == FUNCT7_ALT && funct3_s == 3'b101) begin
                    alu_s = 6'b001101;
                end else begin
                    alu_s = {3'b000, funct3_s};
                end
            end
            OP_IMM: begin
                imm_s = imm_i_s;
                wen_s = 1'b1;
                // Only srai is distinguished by funct7; other shifts keep the raw shamt field.
                if (funct7_s == FUNCT7_ALT && funct3_s == 3'b101) begin
                    alu_s = 6'b001101;
                end else begin
                    alu_s = {3'b000, funct3_s};
                end
            end
            OP_LOAD: begin
                imm_s = imm_i_s;
                wen_s = 1'b1;
                wbs_s = 1'b1;
            end
            OP_STORE: begin
                imm_s  = imm_st_s;
                mwen_s = 1'b1;
            end
            OP_BRANCH: begin
                imm_s = imm_b_s;
                opb_s = 1'b0;
                bop_s = 1'b1;
                alu_s = {3'b010, funct3_s};
                tgt_s = PC + imm_b_s[ADDRESS_BITS-1:0];
            end
            OP_JAL: begin
                imm_s  = imm_j_s;
                wen_s  = 1'b1;
                opa_s  = 2'b10;
                alu_s  = 6'b011111;
                jump_s = 1'b1;
                tgt_s  = PC + imm_j_s[ADDRESS_BITS-1:0];
            end
            OP_JALR: begin
                imm_s  = imm_i_s;
                wen_s  = 1'b1;
                opa_s  = 2'b10;
                alu_s  = 6'b011111;
                jump_s = 1'b1;
                tgt_s  = JALR_target;
            end
            OP_LUI: begin
                imm_s = imm_u_s;
                wen_s = 1'b1;
                lui_s = 1'b1;
            end
            OP_AUIPC: begin
                imm_s = imm_u_s;
                wen_s = 1'b1;
                opa_s = 2'b01;
            end
            default: begin
                imm_s = 32'd0;
            end
        endcase
    end

    assign read_sel1      = lui_s ? 5'd0 : instruction[19:15];
    assign read_sel2      = instruction[24:20];
    assign write_sel      = instruction[11:7];
    assign imm32          = imm_s;
    assign ALU_Control    = alu_s;
    assign op_A_sel       = opa_s;
    assign op_B_sel       = opb_s;
    assign wb_sel         = wbs_s;
    assign branch_op      = bop_s;
    assign target_PC      = tgt_s;
    assign wEn            = wen_s & run_q;
    assign mem_wEn        = mwen_s & run_q;
    assign next_PC_select = run_q & (jump_s | (bop_s & branch));

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: hand-derived expected decodes are queued as
// stimulus is applied and popped when the combinational outputs have settled.
module tb_decode_unit;

    localparam int AB = 16;

    logic          clock;
    logic          reset;
    logic [AB-1:0] PC;
    logic [31:0]   instruction;
    logic [AB-1:0] JALR_target;
    logic          branch;
    logic          next_PC_select;
    logic [AB-1:0] target_PC;
    logic [4:0]    read_sel1;
    logic [4:0]    read_sel2;
    logic [4:0]    write_sel;
    logic          wEn;
    logic          branch_op;
    logic [31:0]   imm32;
    logic [1:0]    op_A_sel;
    logic          op_B_sel;
    logic [5:0]    ALU_Control;
    logic          mem_wEn;
    logic          wb_sel;

    typedef struct packed {
        logic          nps;
        logic [AB-1:0] tpc;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic          wen;
        logic          bop;
        logic [31:0]   imm;
        logic [1:0]    opa;
        logic          opb;
        logic [5:0]    alu;
        logic          mwen;
        logic          wbs;
    } dec_t;

    dec_t sb_q[$];
    int   n_checks;
    int   n_errors;

    decode_unit #(.ADDRESS_BITS(AB)) dut (
        .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
        .JALR_target(JALR_target), .branch(branch),
        .next_PC_select(next_PC_select), .target_PC(target_PC),
        .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
        .wEn(wEn), .branch_op(branch_op), .imm32(imm32), .op_A_sel(op_A_sel),
        .op_B_sel(op_B_sel), .ALU_Control(ALU_Control), .mem_wEn(mem_wEn),
        .wb_sel(wb_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic dec_t mk(input logic nps, input logic [AB-1:0] tpc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic wen, input logic bop,
                                input logic [31:0] imm, input logic [1:0] opa,
                                input logic opb, input logic [5:0] alu,
                                input logic mwen, input logic wbs);
        dec_t d;
        d.nps = nps; d.tpc = tpc; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
        d.wen = wen; d.bop = bop; d.imm = imm; d.opa = opa; d.opb = opb;
        d.alu = alu; d.mwen = mwen; d.wbs = wbs;
        return d;
    endfunction

    function automatic dec_t observe();
        return mk(next_PC_select, target_PC, read_sel1, read_sel2, write_sel, wEn,
                  branch_op, imm32, op_A_sel, op_B_sel, ALU_Control, mem_wEn, wb_sel);
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [AB-1:0] pc,
                         input logic [AB-1:0] jt, input logic br);
        @(negedge clock);
        instruction = ins;
        PC          = pc;
        JALR_target = jt;
        branch      = br;
    endtask

    task automatic test_reset();
        dec_t obs;
        dec_t e;
        reset = 1'b0;
        instruction = 32'h0140006f; PC = 16'h0114; JALR_target = 16'h0000; branch = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        sb_q.push_back(mk(1'b0, 16'h0128, 5'd0, 5'd20, 5'd0, 1'b0, 1'b0, 32'h14,
                          2'b10, 1'b1, 6'h1F, 1'b0, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL reset_hold: got %h expected %h", obs, e);
        end
        reset = 1'b1;
        sb_q.push_back(mk(1'b0, 16'h0128, 5'd0, 5'd20, 5'd0, 1'b0, 1'b0, 32'h14,
                          2'b10, 1'b1, 6'h1F, 1'b0, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL reset_release_pre_edge: got %h expected %h", obs, e);
        end
        @(negedge clock);
        sb_q.push_back(mk(1'b1, 16'h0128, 5'd0, 5'd20, 5'd0, 1'b1, 1'b0, 32'h14,
                          2'b10, 1'b1, 6'h1F, 1'b0, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL reset_release_post_edge: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins [6];
        dec_t        ex  [6];
        dec_t        obs;
        dec_t        e;
        ins[0] = 32'h00000013;
        ex[0]  = mk(1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 6'h00, 1'b0, 1'b0);
        ins[1] = 32'hFFF00593;
        ex[1]  = mk(1'b0, 16'h0, 5'd0, 5'd31, 5'd11, 1'b1, 1'b0, 32'hFFFFFFFF, 2'b00, 1'b1, 6'h00, 1'b0, 1'b0);
        ins[2] = 32'h40E608B3;
        ex[2]  = mk(1'b0, 16'h0, 5'd12, 5'd14, 5'd17, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 6'h08, 1'b0, 1'b0);
        ins[3] = 32'h40415093;
        ex[3]  = mk(1'b0, 16'h0, 5'd2, 5'd4, 5'd1, 1'b1, 1'b0, 32'h00000404, 2'b00, 1'b1, 6'h0D, 1'b0, 1'b0);
        ins[4] = 32'h123452B7;
        ex[4]  = mk(1'b0, 16'h0, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 32'h12345000, 2'b00, 1'b1, 6'h00, 1'b0, 1'b0);
        ins[5] = 32'hFFFFF317;
        ex[5]  = mk(1'b0, 16'h0, 5'd31, 5'd31, 5'd6, 1'b1, 1'b0, 32'hFFFFF000, 2'b01, 1'b1, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], 16'h0040, 16'h0000, 1'b0);
            sb_q.push_back(ex[i]);
            #1;
            obs = observe(); e = sb_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_errors++; $display("FAIL alu_%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_mem();
        dec_t obs;
        dec_t e;
        drive(32'h00C5A023, 16'h0010, 16'h0000, 1'b0);
        sb_q.push_back(mk(1'b0, 16'h0, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 6'h00, 1'b1, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL store: got %h expected %h", obs, e);
        end
        drive(32'h0005A903, 16'h0014, 16'h0000, 1'b0);
        sb_q.push_back(mk(1'b0, 16'h0, 5'd11, 5'd0, 5'd18, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 6'h00, 1'b0, 1'b1));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL load: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_jump();
        logic [31:0]   ins [3];
        logic [AB-1:0] pcs [3];
        dec_t          ex  [3];
        dec_t          obs;
        dec_t          e;
        ins[0] = 32'h0140006f; pcs[0] = 16'h0114;
        ex[0]  = mk(1'b1, 16'h0128, 5'd0, 5'd20, 5'd0, 1'b1, 1'b0, 32'h14, 2'b10, 1'b1, 6'h1F, 1'b0, 1'b0);
        ins[1] = 32'h0c4080e7; pcs[1] = 16'h0200;
        ex[1]  = mk(1'b1, 16'h0154, 5'd1, 5'd4, 5'd1, 1'b1, 1'b0, 32'd196, 2'b10, 1'b1, 6'h1F, 1'b0, 1'b0);
        // backward jump from near zero wraps the 16-bit target
        ins[2] = 32'hFF1FF06F; pcs[2] = 16'h0008;
        ex[2]  = mk(1'b1, 16'hFFF8, 5'd31, 5'd17, 5'd0, 1'b1, 1'b0, 32'hFFFFFFF0, 2'b10, 1'b1, 6'h1F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], pcs[i], 16'h0154, 1'b0);
            sb_q.push_back(ex[i]);
            #1;
            obs = observe(); e = sb_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_errors++; $display("FAIL jump_%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3 [7];
        logic        br [7];
        logic [31:0] ins;
        dec_t        obs;
        dec_t        e;
        f3[0] = 3'b000; br[0] = 1'b0;
        f3[1] = 3'b000; br[1] = 1'b1;
        f3[2] = 3'b001; br[2] = 1'b1;
        f3[3] = 3'b100; br[3] = 1'b0;
        f3[4] = 3'b101; br[4] = 1'b1;
        f3[5] = 3'b110; br[5] = 1'b0;
        f3[6] = 3'b111; br[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ins = 32'h02208063 | ({29'd0, f3[i]} << 12);
            drive(ins, 16'h0004, 16'h0000, br[i]);
            sb_q.push_back(mk(br[i], 16'h0024, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 32'd32,
                              2'b00, 1'b0, {3'b010, f3[i]}, 1'b0, 1'b0));
            #1;
            obs = observe(); e = sb_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_errors++; $display("FAIL branch_%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_unknown();
        dec_t obs;
        dec_t e;
        drive(32'hFFFFFFFF, 16'h0100, 16'h0154, 1'b1);
        sb_q.push_back(mk(1'b0, 16'h0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 6'h00, 1'b0, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL unknown_opcode: got %h expected %h", obs, e);
        end
        drive(32'h40E608B3, 16'h0100, 16'h0154, 1'b1);
        sb_q.push_back(mk(1'b0, 16'h0, 5'd12, 5'd14, 5'd17, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 6'h08, 1'b0, 1'b0));
        #1;
        obs = observe(); e = sb_q.pop_front(); n_checks++;
        if (obs !== e) begin
            n_errors++; $display("FAIL branch_on_non_branch: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic on_e [4];
        dec_t obs;
        dec_t e;
        drive(32'h0140006f, 16'h0114, 16'h0000, 1'b0);
        reset = 1'b0;
        on_e[0] = 1'b1; on_e[1] = 1'b0; on_e[2] = 1'b0; on_e[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 2) reset = 1'b1;
            sb_q.push_back(mk(on_e[i], 16'h0128, 5'd0, 5'd20, 5'd0, on_e[i], 1'b0, 32'h14,
                              2'b10, 1'b1, 6'h1F, 1'b0, 1'b0));
            #1;
            obs = observe(); e = sb_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_errors++; $display("FAIL midop_reset_%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        PC = '0; instruction = 32'h00000013; JALR_target = '0; branch = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_jump();
        test_branch();
        test_unknown();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
# decode_unit

Combinational RV32I instruction decoder for the single-cycle processor, with one registered run-enable flag. It sits between fetch and the register file/ALU. It turns the fetched instruction into:
- register selects,
- a sign-extended immediate,
- ALU operand selects and opcode,
- memory/writeback controls,
- next-PC redirect.

State-changing strobes are suppressed until the core leaves reset.

## Interface
- ADDRESS_BITS, 16, width of PC and target addresses
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- PC  in  ADDRESS_BITS  address of current instruction
- instruction  in  32  fetched instruction
- JALR_target  in  ADDRESS_BITS  rs1+imm computed by the ALU, used for JALR
- branch  in  1  ALU branch-condition result
- next_PC_select  out  1  1 = fetch loads target_PC
- target_PC  out  ADDRESS_BITS  redirect address
- read_sel1 / read_sel2 / write_sel  out  5 each  rs1 / rs2 / rd selects
- wEn  out  1  register-file write enable
- branch_op  out  1  instruction is a conditional branch
- imm32  out  32  decoded immediate
- op_A_sel  out  2  00 rs1, 01 PC, 10 PC+4, 11 reserved (treated as rs1)
- op_B_sel  out  1  0 rs2, 1 imm32
- ALU_Control  out  6  ALU operation
- mem_wEn  out  1  data-memory write enable
- wb_sel  out  1  0 ALU result, 1 memory data

## Operation
- Field decode:
  - read_sel1 = inst[19:15], forced 0 for LUI.
  - read_sel2 = inst[24:20].
  - write_sel = inst[11:7].
- Immediates:
  - I-type (OP-IMM 0010011, LOAD 0000011, JALR 1100111): sext(inst[31:20]). Shifts pass the raw field; the ALU uses imm32[4:0].
  - S-type (0100011): sext({inst[31:25],inst[11:7]}).
  - B-type (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): {inst[31:12],12'b0}.
  - J-type (JAL 1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R-type and unknown opcodes: 0.
- ALU_Control:
  - {3'b000,funct3}: R-type with funct7=0, and all OP-IMM except srai.
  - 6'b001000: sub.
  - 6'b001101: sra and srai (funct7 = 0100000).
  - {3'b010,funct3}: branches.
  - 6'b011111: JAL and JALR (pass operand A).
  - 6'b000000: LOAD, STORE, LUI, AUIPC.
- Operand selects:
  - op_A_sel = 01 for AUIPC, 10 for JAL/JALR, else 00.
  - op_B_sel = 0 for R-type and branch, else 1.
- Controls:
  - wEn = 1 for R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. It is not gated by rd=0.
  - mem_wEn = 1 for STORE only.
  - wb_sel = 1 for LOAD only.
  - branch_op = 1 for opcode 1100011.
- Next PC:
  - target_PC = JALR_target for JALR.
  - target_PC = PC + imm32[ADDRESS_BITS-1:0] for JAL and branches, wrapping modulo 2^ADDRESS_BITS.
  - target_PC = 0 otherwise.
  - next_PC_select = JAL | JALR | (branch_op & branch).
- Unknown opcode: wEn = mem_wEn = next_PC_select = branch_op = 0, and ALU_Control = 0.

## Timing
- All decode outputs are combinational from the inputs, with zero-cycle latency.
- One flop, run:
  - run is cleared on a rising clock edge while reset=0.
  - run is set on the first rising edge with reset=1.
- While run=0, wEn, mem_wEn and next_PC_select are forced 0. All other outputs still decode normally.
- Asserting reset mid-operation clears run at the next edge. The strobes drop after that edge, not before.
- Simultaneous branch=1 on a non-branch instruction has no effect.

## Test plan
Out of reset (run=1) unless noted:
- NOP 0x00000013 -> ALU_Control 000000, imm32 0, op_B_sel 1, wEn 1, write_sel 0, next_PC_select 0.
- addi a1,zero,-1:
  - imm32 0xFFFFFFFF, write_sel 11, wEn 1.
  - Then sub a7,a2,a4 -> read 12/14, write 17, ALU_Control 001000, op_B_sel 0.
- sw a2,0(a1) -> mem_wEn 1, wEn 0, read 11/12, imm32 0. Then lw s2,0(a1) -> wb_sel 1, wEn 1, write_sel 18.
- Jumps:
  - JAL 0x0140006f at PC 0x0114 -> target_PC 0x0128, next_PC_select 1, op_A_sel 10, write_sel 0.
  - JALR 0x0c4080e7 with JALR_target 0x0154 -> target_PC 0x0154, imm32 196.
- Branch 0x02208063 (beq x1,x2) at PC 0x0004 -> imm32 32, target_PC 0x0024, branch_op 1, ALU_Control 010000. next_PC_select follows branch (0 then 1); funct3 001/100/101/110/111 gives ALU_Control 010001/010100/010101/010110/010111.
- srai x1,x2,4 -> ALU_Control 001101, imm32[4:0]=4.
- Reset:
  - Hold reset=0 for 2 edges with JAL applied -> next_PC_select 0 and wEn 0 while target_PC remains 0x0128.
  - Release reset -> strobes assert after the next rising edge.
